// File: rtl/mine_field_engine.sv
// Saper minefield engine: LFSR mine placement into a run-time sized bitmap and reveal/flag resolution.
// Define MINE_NEIGHBOUR_COUNT_EN to add the 8-cycle neighbour-mine scan on safe reveals.
`timescale 1ns/1ps
module mine_field_engine #(
  parameter int unsigned MAX_DIM   = 16,
  parameter int unsigned IDX_W     = 5,
  parameter int unsigned CNT_W     = 9,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       gen_start,
  input  logic [IDX_W-1:0]           dim,
  input  logic [CNT_W-1:0]           mines_num,
  output logic                       busy,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_op,
  input  logic [IDX_W-1:0]           cmd_x,
  input  logic [IDX_W-1:0]           cmd_y,
  output logic                       explode,
  output logic                       defuse,
  output logic                       mark_flag,
  output logic [3:0]                 cell_count,
  output logic [CNT_W-1:0]           flags_placed,
  output logic [MAX_DIM*MAX_DIM-1:0] mine_map,
  output logic [MAX_DIM*MAX_DIM-1:0] flag_map
);
  localparam int unsigned CELLS  = MAX_DIM * MAX_DIM;
  localparam int unsigned CELL_W = $clog2(CELLS);
  localparam int unsigned SQ_W   = 2 * IDX_W;
  localparam int unsigned CMP_W  = (SQ_W > CNT_W) ? SQ_W : CNT_W;
  localparam int unsigned NB_W   = IDX_W + 1;

  localparam logic [15:0]      LFSR_TAPS = 16'hB400;
  localparam logic [IDX_W-1:0] DIM_MAX   = IDX_W'(MAX_DIM);
  localparam logic [IDX_W-1:0] DIM_MIN   = IDX_W'(1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_PLACE = 3'd2;
  localparam logic [2:0] ST_READY = 3'd3;
  localparam logic [2:0] ST_CHECK = 3'd4;
`ifdef MINE_NEIGHBOUR_COUNT_EN
  localparam logic [2:0] ST_COUNT = 3'd5;
`endif
  localparam logic [2:0] ST_DEAD  = 3'd6;

  // Row-major cell address; callers mask out-of-range coordinates themselves.
  function automatic logic [CELL_W-1:0] cell_idx(input logic [NB_W-1:0] x, input logic [NB_W-1:0] y);
    return CELL_W'(32'(y) * MAX_DIM + 32'(x));
  endfunction

  logic [2:0]             state, state_nxt;
  logic [15:0]            lfsr, lfsr_nxt;
  logic [IDX_W-1:0]       dim_eff, dim_eff_nxt;
  logic [CNT_W-1:0]       mines_eff, mines_eff_nxt;
  logic [CNT_W-1:0]       remaining, remaining_nxt;
  logic [CELLS-1:0]       mine_map_nxt, flag_map_nxt;
  logic [CNT_W-1:0]       flags_nxt;
  logic                   cmd_op_q, cmd_op_nxt;
  logic [IDX_W-1:0]       cmd_x_q, cmd_x_nxt, cmd_y_q, cmd_y_nxt;
  logic                   explode_nxt, defuse_nxt, mark_nxt;
  logic [3:0]             cell_count_nxt;

  logic [IDX_W-1:0]       dim_clamp_c;
  logic [CMP_W-1:0]       cap_c;
  logic [CNT_W-1:0]       mines_clamp_c;
  logic [NB_W-1:0]        dim_e_c, cand_x_c, cand_y_c;
  logic [CELL_W-1:0]      cand_idx_c, tgt_idx_c;
  logic                   cand_ok_c, tgt_in_c;

`ifdef MINE_NEIGHBOUR_COUNT_EN
  localparam logic [NB_W-1:0] NB_ONE = NB_W'(1);
  logic [2:0]             nb_idx, nb_idx_nxt;
  logic [3:0]             nb_acc, nb_acc_nxt;
  logic [NB_W-1:0]        nb_x_c, nb_y_c, cur_x_c, cur_y_c;
  logic                   nb_hit_c;
`endif

  assign busy      = (state == ST_CLEAR) || (state == ST_PLACE);
  assign cmd_ready = (state == ST_READY) && !gen_start;

  // Board size and mine count limits applied when a generation starts.
  always_comb begin
    if (dim == '0) dim_clamp_c = DIM_MIN;
    else if (dim > DIM_MAX) dim_clamp_c = DIM_MAX;
    else dim_clamp_c = dim;
    cap_c = CMP_W'(dim_clamp_c) * CMP_W'(dim_clamp_c) - CMP_W'(1);
    if (CMP_W'(mines_num) > cap_c) mines_clamp_c = CNT_W'(cap_c);
    else mines_clamp_c = mines_num;
  end

  // Placement candidate and command target decoding.
  always_comb begin
    dim_e_c    = {1'b0, dim_eff};
    cand_x_c   = {1'b0, lfsr[IDX_W-1:0]};
    cand_y_c   = {1'b0, lfsr[2*IDX_W-1:IDX_W]};
    cand_idx_c = cell_idx(cand_x_c, cand_y_c);
    cand_ok_c  = (cand_x_c < dim_e_c) && (cand_y_c < dim_e_c) && !mine_map[cand_idx_c];
    tgt_in_c   = (cmd_x_q < dim_eff) && (cmd_y_q < dim_eff);
    tgt_idx_c  = cell_idx({1'b0, cmd_x_q}, {1'b0, cmd_y_q});
  end

`ifdef MINE_NEIGHBOUR_COUNT_EN
  // Neighbour under scan, order N, NE, E, SE, S, SW, W, NW; underflow wraps high so it reads as out of range.
  always_comb begin
    cur_x_c = {1'b0, cmd_x_q};
    cur_y_c = {1'b0, cmd_y_q};
    nb_x_c  = cur_x_c;
    nb_y_c  = cur_y_c;
    case (nb_idx)
      3'd0: nb_y_c = cur_y_c - NB_ONE;
      3'd1: begin nb_x_c = cur_x_c + NB_ONE; nb_y_c = cur_y_c - NB_ONE; end
      3'd2: nb_x_c = cur_x_c + NB_ONE;
      3'd3: begin nb_x_c = cur_x_c + NB_ONE; nb_y_c = cur_y_c + NB_ONE; end
      3'd4: nb_y_c = cur_y_c + NB_ONE;
      3'd5: begin nb_x_c = cur_x_c - NB_ONE; nb_y_c = cur_y_c + NB_ONE; end
      3'd6: nb_x_c = cur_x_c - NB_ONE;
      3'd7: begin nb_x_c = cur_x_c - NB_ONE; nb_y_c = cur_y_c - NB_ONE; end
    endcase
    nb_hit_c = (nb_x_c < dim_e_c) && (nb_y_c < dim_e_c) && mine_map[cell_idx(nb_x_c, nb_y_c)];
  end
`endif

  // Next-state and registered-output logic; gen_start overrides every state.
  always_comb begin
    state_nxt      = state;
    lfsr_nxt       = lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);
    dim_eff_nxt    = dim_eff;
    mines_eff_nxt  = mines_eff;
    remaining_nxt  = remaining;
    mine_map_nxt   = mine_map;
    flag_map_nxt   = flag_map;
    flags_nxt      = flags_placed;
    cmd_op_nxt     = cmd_op_q;
    cmd_x_nxt      = cmd_x_q;
    cmd_y_nxt      = cmd_y_q;
    explode_nxt    = 1'b0;
    defuse_nxt     = 1'b0;
    mark_nxt       = 1'b0;
    cell_count_nxt = cell_count;
`ifdef MINE_NEIGHBOUR_COUNT_EN
    nb_idx_nxt     = nb_idx;
    nb_acc_nxt     = nb_acc;
`endif
    if (gen_start) begin
      state_nxt     = ST_CLEAR;
      dim_eff_nxt   = dim_clamp_c;
      mines_eff_nxt = mines_clamp_c;
    end else begin
      case (state)
        ST_IDLE: state_nxt = ST_IDLE;
        ST_CLEAR: begin
          mine_map_nxt  = '0;
          flag_map_nxt  = '0;
          flags_nxt     = '0;
          remaining_nxt = mines_eff;
          state_nxt     = (mines_eff == '0) ? ST_READY : ST_PLACE;
        end
        ST_PLACE: begin
          if (cand_ok_c) begin
            mine_map_nxt[cand_idx_c] = 1'b1;
            remaining_nxt = remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) state_nxt = ST_READY;
          end
        end
        ST_READY: begin
          if (cmd_valid) begin
            cmd_op_nxt = cmd_op;
            cmd_x_nxt  = cmd_x;
            cmd_y_nxt  = cmd_y;
            state_nxt  = ST_CHECK;
          end
        end
        ST_CHECK: begin
          state_nxt = ST_READY;
          if (tgt_in_c) begin
            if (cmd_op_q) begin
              flag_map_nxt[tgt_idx_c] = ~flag_map[tgt_idx_c];
              flags_nxt = flag_map[tgt_idx_c] ? (flags_placed - CNT_W'(1))
                                              : (flags_placed + CNT_W'(1));
              mark_nxt  = 1'b1;
            end else if (!flag_map[tgt_idx_c]) begin
              if (mine_map[tgt_idx_c]) begin
                explode_nxt = 1'b1;
                state_nxt   = ST_DEAD;
              end else begin
`ifdef MINE_NEIGHBOUR_COUNT_EN
                nb_idx_nxt = 3'd0;
                nb_acc_nxt = 4'd0;
                state_nxt  = ST_COUNT;
`else
                defuse_nxt = 1'b1;
`endif
              end
            end
          end
        end
`ifdef MINE_NEIGHBOUR_COUNT_EN
        ST_COUNT: begin
          nb_idx_nxt = nb_idx + 3'd1;
          nb_acc_nxt = nb_acc + {3'b000, nb_hit_c};
          if (nb_idx == 3'd7) begin
            cell_count_nxt = nb_acc + {3'b000, nb_hit_c};
            defuse_nxt     = 1'b1;
            state_nxt      = ST_READY;
          end
        end
`endif
        ST_DEAD: state_nxt = ST_DEAD;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      lfsr         <= LFSR_SEED;
      dim_eff      <= DIM_MIN;
      mines_eff    <= '0;
      remaining    <= '0;
      mine_map     <= '0;
      flag_map     <= '0;
      flags_placed <= '0;
      cmd_op_q     <= 1'b0;
      cmd_x_q      <= '0;
      cmd_y_q      <= '0;
      explode      <= 1'b0;
      defuse       <= 1'b0;
      mark_flag    <= 1'b0;
      cell_count   <= 4'd0;
`ifdef MINE_NEIGHBOUR_COUNT_EN
      nb_idx       <= 3'd0;
      nb_acc       <= 4'd0;
`endif
    end else begin
      state        <= state_nxt;
      lfsr         <= lfsr_nxt;
      dim_eff      <= dim_eff_nxt;
      mines_eff    <= mines_eff_nxt;
      remaining    <= remaining_nxt;
      mine_map     <= mine_map_nxt;
      flag_map     <= flag_map_nxt;
      flags_placed <= flags_nxt;
      cmd_op_q     <= cmd_op_nxt;
      cmd_x_q      <= cmd_x_nxt;
      cmd_y_q      <= cmd_y_nxt;
      explode      <= explode_nxt;
      defuse       <= defuse_nxt;
      mark_flag    <= mark_nxt;
      cell_count   <= cell_count_nxt;
`ifdef MINE_NEIGHBOUR_COUNT_EN
      nb_idx       <= nb_idx_nxt;
      nb_acc       <= nb_acc_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_mine_field_engine.sv
// Scoreboard bench for mine_field_engine: a reference LFSR/placement model predicts maps and pulses,
// expected pulses are queued at command acceptance and matched when the DUT pulses.
`timescale 1ns/1ps
module tb_mine_field_engine;
  localparam int unsigned MAX_DIM = 16;
  localparam int unsigned IDX_W   = 5;
  localparam int unsigned CNT_W   = 9;
  localparam int unsigned CELLS   = MAX_DIM * MAX_DIM;
  localparam logic [15:0] SEED    = 16'hACE1;
`ifdef MINE_NEIGHBOUR_COUNT_EN
  localparam int LAT = 9;
  localparam int ABORT_WAIT = 2;
  localparam bit CNT_ON = 1'b1;
`else
  localparam int LAT = 1;
  localparam int ABORT_WAIT = 0;
  localparam bit CNT_ON = 1'b0;
`endif
  localparam int K_NONE = 0, K_EXPLODE = 1, K_DEFUSE = 2, K_MARK = 3;

  typedef struct { int kind; int cnt; int due; } exp_t;

  logic clk = 1'b0;
  logic rst, gen_start, cmd_valid, cmd_op;
  logic [IDX_W-1:0] dim, cmd_x, cmd_y;
  logic [CNT_W-1:0] mines_num, flags_placed;
  logic busy, cmd_ready, explode, defuse, mark_flag;
  logic [3:0] cell_count;
  logic [CELLS-1:0] mine_map, flag_map;

  mine_field_engine dut (
    .clk(clk), .rst(rst), .gen_start(gen_start), .dim(dim), .mines_num(mines_num), .busy(busy),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y),
    .explode(explode), .defuse(defuse), .mark_flag(mark_flag), .cell_count(cell_count),
    .flags_placed(flags_placed), .mine_map(mine_map), .flag_map(flag_map)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_miss = 0;
  int cyc = 0;
  exp_t sb[$];

  logic [15:0]      m_lfsr;
  logic [CELLS-1:0] m_mine = '0;
  logic [CELLS-1:0] m_flag = '0;
  int m_dim = 1;
  int m_flags = 0;

  task automatic check_eq(input string tag, input logic [CELLS-1:0] act, input logic [CELLS-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  function automatic int nb_count(input int x, input int y);
    int c = 0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        if ((dx != 0 || dy != 0) && x + dx >= 0 && x + dx < m_dim && y + dy >= 0 && y + dy < m_dim)
          if (m_mine[(y + dy) * MAX_DIM + x + dx]) c++;
    return c;
  endfunction

  function automatic exp_t predict(input logic op, input int x, input int y);
    exp_t e;
    int i;
    e.kind = K_NONE; e.cnt = 0; e.due = 0;
    if (x < m_dim && y < m_dim) begin
      i = y * MAX_DIM + x;
      if (op) begin
        m_flag[i] = ~m_flag[i];
        m_flags += m_flag[i] ? 1 : -1;
        e.kind = K_MARK;
      end else if (!m_flag[i]) begin
        if (m_mine[i]) e.kind = K_EXPLODE;
        else begin
          e.kind = K_DEFUSE;
          e.cnt = CNT_ON ? nb_count(x, y) : 0;
        end
      end
    end
    return e;
  endfunction

  // Reference LFSR, free-running from reset release like the DUT's.
  always @(posedge clk or negedge rst) begin
    if (!rst) m_lfsr <= SEED;
    else m_lfsr <= lfsr_step(m_lfsr);
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: pops the scoreboard on each pulse, flags late or unexpected pulses.
  always @(negedge clk) begin
    int hot, kind;
    exp_t e;
    if (rst) begin
      if (sb.size() != 0 && sb[0].due < cyc) begin
        e = sb.pop_front();
        check_eq("pulse_missing", cyc, e.due);
      end
      hot = int'(explode) + int'(defuse) + int'(mark_flag);
      if (hot > 1) check_eq("pulse_onehot", hot, 1);
      else if (hot == 1) begin
        kind = explode ? K_EXPLODE : (defuse ? K_DEFUSE : K_MARK);
        if (sb.size() == 0) check_eq("unexpected_pulse", kind, K_NONE);
        else begin
          e = sb.pop_front();
          check_eq("pulse_kind", kind, e.kind);
          check_eq("pulse_cycle", cyc, e.due);
          if (defuse) check_eq("cell_count", cell_count, e.cnt);
        end
      end
    end
  end

  task automatic gen(input int d, input int m);
    logic [15:0] l;
    int de, me, n, placed, x, y, cyc_b;
    @(negedge clk);
    dim = IDX_W'(d); mines_num = CNT_W'(m); gen_start = 1'b1;
    @(posedge clk); #1;
    gen_start = 1'b0;
    de = (d == 0) ? 1 : ((d > MAX_DIM) ? MAX_DIM : d);
    me = (m < de * de - 1) ? m : de * de - 1;
    m_dim = de; m_mine = '0; m_flag = '0; m_flags = 0;
    l = lfsr_step(m_lfsr);
    n = 0; placed = 0;
    while (placed < me && n < 70000) begin
      x = int'(l[4:0]); y = int'(l[9:5]);
      if (x < de && y < de && !m_mine[y * MAX_DIM + x]) begin
        m_mine[y * MAX_DIM + x] = 1'b1;
        placed++;
      end
      l = lfsr_step(l);
      n++;
    end
    cyc_b = 0;
    while (busy && cyc_b < n + 20) begin
      @(posedge clk); #1;
      cyc_b++;
    end
    check_eq("busy_cycles", cyc_b, n + 1);
    check_eq("mine_map", mine_map, m_mine);
    check_eq("mine_popcount", $countones(mine_map), me);
    check_eq("flag_map_cleared", flag_map, '0);
    check_eq("flags_cleared", flags_placed, 0);
    check_eq("ready_after_gen", cmd_ready, 1);
  endtask

  task automatic send(input logic op, input int x, input int y, input bit push);
    int w, t;
    exp_t e;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_x = IDX_W'(x); cmd_y = IDX_W'(y);
    #1;
    w = 0;
    while (!cmd_ready && w < 100) begin
      @(negedge clk); #1;
      w++;
    end
    if (!cmd_ready) begin
      check_eq("cmd_accept_timeout", 0, 1);
      cmd_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      t = cyc;
      cmd_valid = 1'b0;
      if (push) begin
        e = predict(op, x, y);
        if (e.kind != K_NONE) begin
          e.due = t + ((e.kind == K_DEFUSE) ? LAT : 1);
          sb.push_back(e);
        end
      end
    end
  endtask

  task automatic settle();
    repeat (LAT + 4) @(negedge clk);
    check_eq("sb_drain", sb.size(), 0);
    check_eq("flags_placed", flags_placed, m_flags);
    check_eq("flag_map", flag_map, m_flag);
  endtask

  initial begin
    int sx, sy, bx, by, best, mx, my, rdy;
    rst = 1'b1; gen_start = 1'b0; dim = '0; mines_num = '0;
    cmd_valid = 1'b0; cmd_op = 1'b0; cmd_x = '0; cmd_y = '0;
    #1 rst = 1'b0;
    #2;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ready", cmd_ready, 0);
    check_eq("rst_pulses", {explode, defuse, mark_flag}, 0);
    check_eq("rst_cell_count", cell_count, 0);
    check_eq("rst_flags", flags_placed, 0);
    check_eq("rst_mine_map", mine_map, '0);
    check_eq("rst_flag_map", flag_map, '0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("idle_ready", cmd_ready, 0);

    gen(8, 10);
    send(1'b1, 3, 4, 1'b1); settle();
    check_eq("flag67_set", flag_map[67], 1);
    send(1'b1, 3, 4, 1'b1); settle();
    check_eq("flag67_clear", flag_map[67], 0);

    sx = 0; sy = 0; bx = 0; by = 0; best = -1;
    for (int y = 7; y >= 0; y--)
      for (int x = 7; x >= 0; x--)
        if (!m_mine[y * MAX_DIM + x]) begin
          sx = x; sy = y;
          if (nb_count(x, y) >= best) begin best = nb_count(x, y); bx = x; by = y; end
        end
    send(1'b1, sx, sy, 1'b1); send(1'b0, sx, sy, 1'b1); send(1'b1, sx, sy, 1'b1); settle();
    send(1'b0, 9, 0, 1'b1); send(1'b1, 0, 8, 1'b1); settle();
    send(1'b0, sx, sy, 1'b1); settle();
    send(1'b0, bx, by, 1'b1); settle();
    send(1'b0, bx, by, 1'b1); settle();
    if (!m_mine[0]) begin send(1'b0, 0, 0, 1'b1); settle(); end

    send(1'b0, bx, by, 1'b0);
    repeat (ABORT_WAIT) @(negedge clk);
    gen(8, 10);
    settle();

    mx = 0; my = 0;
    for (int i = CELLS - 1; i >= 0; i--)
      if (m_mine[i]) begin mx = i % MAX_DIM; my = i / MAX_DIM; end
    send(1'b0, mx, my, 1'b1); settle();
    rdy = 0;
    repeat (50) begin
      @(negedge clk);
      if (cmd_ready) rdy++;
    end
    check_eq("dead_ready_cycles", rdy, 0);

    gen(8, 100);
    check_eq("full_board_mines", $countones(mine_map), 63);
    gen(0, 5);

    @(negedge clk);
    dim = IDX_W'(8); mines_num = CNT_W'(100); gen_start = 1'b1;
    @(negedge clk);
    gen_start = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("busy_in_place", busy, 1);
    #2 rst = 1'b0;
    #1;
    check_eq("arst_busy", busy, 0);
    check_eq("arst_mine_map", mine_map, '0);
    check_eq("arst_flag_map", flag_map, '0);
    check_eq("arst_cell_count", cell_count, 0);
    check_eq("arst_ready", cmd_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    gen(8, 10);
    send(1'b0, bx, by, 1'b1); settle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/mine_field_engine.md
Name: mine_field_engine

Overview:
- Parametrised minefield generator and click resolver for the Saper game.
- Replaces the fixed easy/medium/hard board arrays with a single MAX_DIM x MAX_DIM bitmap sized at run time.
- Places mines sequentially with an internal LFSR and resolves reveal/flag commands through a valid/ready handshake.
- Sits between index detection (mouse → cell x/y) and the board renderer/game FSM.

Parameters:
- MAX_DIM, 16: largest board edge; cells are indexed y*MAX_DIM+x.
- IDX_W, 5: width of x/y/dim fields; must satisfy 2^IDX_W > MAX_DIM.
- CNT_W, 9: width of mine and flag counters.
- LFSR_SEED, 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: asynchronous, active-low reset.
- gen_start, in, 1: pulse; start or restart board generation.
- dim, in, IDX_W: active board edge.
- mines_num, in, CNT_W: requested mine count.
- busy, out, 1: high during clear and placement.
- cmd_valid, in, 1: command request.
- cmd_ready, out, 1: command accepted on an edge where cmd_valid and cmd_ready are both high.
- cmd_op, in, 1: 0 = reveal, 1 = toggle flag.
- cmd_x, in, IDX_W: target cell column.
- cmd_y, in, IDX_W: target cell row.
- explode, out, 1: 1-cycle pulse; a mine was revealed.
- defuse, out, 1: 1-cycle pulse; a safe cell was revealed.
- mark_flag, out, 1: 1-cycle pulse; a flag was toggled.
- cell_count, out, 4: neighbour-mine count, valid with defuse.
- flags_placed, out, CNT_W: number of flags currently set.
- mine_map, out, MAX_DIM*MAX_DIM: mine bitmap.
- flag_map, out, MAX_DIM*MAX_DIM: flag bitmap.

Behaviour:
- Reset values:
  - FSM enters IDLE.
  - All maps are 0; flags_placed = 0; cell_count = 0.
  - All pulse outputs are 0; busy = 0; cmd_ready = 0.
  - LFSR = LFSR_SEED.
- LFSR:
  - 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1.
  - Advances every cycle from reset release and never stalls.
  - Candidate x = lfsr[IDX_W-1:0]; candidate y = lfsr[2*IDX_W-1:IDX_W].
- Clamping, latched at gen_start:
  - dim_eff = min(max(dim,1), MAX_DIM).
  - mines_eff = min(mines_num, dim_eff^2 - 1).
- FSM states: IDLE, CLEAR, PLACE, READY, CHECK, COUNT, DEAD.
- gen_start from any state: go to CLEAR on the next edge. Any command in flight is aborted with no pulse.
- CLEAR (1 cycle): zero mine_map, flag_map and flags_placed. Go to PLACE, or straight to READY if mines_eff == 0.
- PLACE, one candidate per cycle:
  - A candidate is rejected if x ≥ dim_eff, y ≥ dim_eff, or the cell is already a mine.
  - Otherwise set the mine bit and decrement the remaining count.
  - Go to READY on the cycle the last mine is placed.
- busy = 1 in CLEAR and PLACE.
- cmd_ready = (state == READY) && !gen_start. gen_start wins any tie with cmd_valid.
- Command handling (T = acceptance edge):
  - Out-of-range x or y: command is consumed; no pulse; return to READY.
  - Flag: toggle the flag bit and adjust flags_placed by ±1. mark_flag is high in the cycle after edge T+1.
  - Reveal of a flagged cell: no pulse; return to READY.
  - Reveal of a mine: explode is high in the cycle after edge T+1; go to DEAD.
  - Reveal of a safe cell: defuse with cell_count (latency set by the optional feature); return to READY.
- DEAD: cmd_ready = 0 until gen_start.
- Revealing an already-revealed safe cell repeats the defuse response. Revealed state is not stored.
- No two pulses are ever high in the same cycle.

Optional Feature:
- Macro: MINE_NEIGHBOUR_COUNT_EN.
- Defined:
  - Safe reveal enters COUNT for 8 cycles, scanning neighbours in order N, NE, E, SE, S, SW, W, NW.
  - Neighbours outside the 0..dim_eff-1 range count as 0.
  - defuse and cell_count are valid in the cycle after edge T+9.
- Not defined:
  - No COUNT state; cell_count stays 0.
  - defuse is high in the cycle after edge T+1.

Test Plan:
- Reset, then dim=8, mines_num=10, pulse gen_start → busy drops within 2000 cycles; popcount(mine_map)=10; no bit set outside x,y<8.
- dim=8, mines_num=100 → exactly 63 mines placed; dim=0 with mines_num=5 → dim_eff=1 and 0 mines, ready after CLEAR.
- Flag (3,4), then flag (3,4) again → two mark_flag pulses; flags_placed 1→0; flag_map bit 67 set, then cleared.
- Reveal a known mine cell at edge T → explode in the cycle after T+1; cmd_ready stays 0 for 50 cycles; gen_start restores cmd_ready.
- With the feature on: force mines at (1,0),(0,1),(1,1) via seed, reveal (0,0) → defuse in the cycle after T+9 with cell_count=3. With it off → defuse in the cycle after T+1, cell_count=0.
- Assert gen_start during COUNT, and rst low during PLACE → no pulse, maps cleared; async reset clears outputs without a clock edge.
